ladybird_bus_arbiter: RTL and testbench

Round-robin arbiter that shares one ladybird peripheral port between N_REQ requesters, such as the core instruction and data ports. It sits between the core-side buses and a single peripheral (RAM, UART) wherever a full crossbar is not needed. It serializes transactions, with one outstanding at a time. Requesters are granted in rotating priority, and each response is routed back to the requester that issued it.

---
 rtl/ladybird_bus_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_ladybird_bus_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ladybird_bus_arbiter.sv
// Round-robin arbiter serializing N_REQ requesters onto one ladybird peripheral port, one
// transaction outstanding. Define LADYBIRD_ARB_TIMEOUT_EN to add the response watchdog.
module ladybird_bus_arbiter #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                             clk_i,
  input  logic                             anrst_i,
  input  logic                             nrst,
  input  logic [N_REQ-1:0]                 req_valid_i,
  output logic [N_REQ-1:0]                 req_ready_o,
  input  logic [N_REQ-1:0][ADDR_W-1:0]     req_addr_i,
  input  logic [N_REQ-1:0]                 req_we_i,
  input  logic [N_REQ-1:0][DATA_W/8-1:0]   req_wstrb_i,
  input  logic [N_REQ-1:0][DATA_W-1:0]     req_wdata_i,
  output logic [N_REQ-1:0]                 rsp_valid_o,
  output logic [DATA_W-1:0]                rsp_data_o,
  output logic                             rsp_err_o,
  output logic [N_REQ-1:0]                 grant_o,
  output logic                             p_valid_o,
  input  logic                             p_ready_i,
  output logic [ADDR_W-1:0]                p_addr_o,
  output logic                             p_we_o,
  output logic [DATA_W/8-1:0]              p_wstrb_o,
  output logic [DATA_W-1:0]                p_wdata_o,
  input  logic                             p_rsp_valid_i,
  input  logic [DATA_W-1:0]                p_rsp_data_i,
  input  logic                             p_rsp_err_i
);

  localparam int unsigned IdxW  = $clog2(N_REQ);
  localparam int unsigned StrbW = DATA_W / 8;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 2 || DATA_W % 8 != 0) begin : g_param_check
    $error("ladybird_bus_arbiter: unsupported parameter combination");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [IdxW-1:0]     last_owner_q, last_owner_d;
  logic [ADDR_W-1:0]   p_addr_q, p_addr_d;
  logic                p_we_q, p_we_d;
  logic [StrbW-1:0]    p_wstrb_q, p_wstrb_d;
  logic [DATA_W-1:0]   p_wdata_q, p_wdata_d;

  logic                live;
  logic                win_found;
  logic [IdxW-1:0]     win_idx;
  int unsigned         cand;
  logic [N_REQ-1:0]    win_1h, own_1h;
  logic                accept;
  logic                tmo_fire;
  logic                rsp_fire;

  // Either reset level forces every combinational output low.
  assign live = anrst_i & nrst;

  // Rotating-priority scan starting just after the previous owner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = (32'(last_owner_q) + i) % N_REQ;
      if (!win_found && req_valid_i[IdxW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IdxW'(cand);
      end
    end
  end

  assign win_1h = N_REQ'(1) << win_idx;
  assign own_1h = N_REQ'(1) << owner_q;
  assign accept = (state_q == StIdle) && win_found;

`ifdef LADYBIRD_ARB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT);

  logic [TmoW-1:0] tmo_q, tmo_d;

  assign tmo_fire = (state_q == StWait) && !p_rsp_valid_i && (tmo_q == TmoW'(TIMEOUT - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == StIssue && p_ready_i) begin
      tmo_d = '0;
    end else if (state_q == StWait && !p_rsp_valid_i) begin
      tmo_d = tmo_q + TmoW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge anrst_i) begin
    if (!anrst_i) begin
      tmo_q <= '0;
    end else if (!nrst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  // A real response in the same cycle as the watchdog expiry takes precedence.
  assign rsp_fire = (state_q == StWait) && (p_rsp_valid_i || tmo_fire);

  // State register.
  always_ff @(posedge clk_i or negedge anrst_i) begin
    if (!anrst_i) begin
      state_q <= StIdle;
    end else if (!nrst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (win_found) state_d = StIssue;
      StIssue: if (p_ready_i) state_d = StWait;
      StWait:  if (rsp_fire)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Command capture and ownership bookkeeping.
  always_comb begin
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    p_addr_d     = p_addr_q;
    p_we_d       = p_we_q;
    p_wstrb_d    = p_wstrb_q;
    p_wdata_d    = p_wdata_q;
    if (accept) begin
      owner_d   = win_idx;
      p_addr_d  = req_addr_i[win_idx];
      p_we_d    = req_we_i[win_idx];
      p_wstrb_d = req_wstrb_i[win_idx];
      p_wdata_d = req_wdata_i[win_idx];
    end
    if (rsp_fire) begin
      last_owner_d = owner_q;
    end
  end

  always_ff @(posedge clk_i or negedge anrst_i) begin
    if (!anrst_i) begin
      owner_q      <= '0;
      last_owner_q <= IdxW'(N_REQ - 1);
      p_addr_q     <= '0;
      p_we_q       <= 1'b0;
      p_wstrb_q    <= '0;
      p_wdata_q    <= '0;
    end else if (!nrst) begin
      owner_q      <= '0;
      last_owner_q <= IdxW'(N_REQ - 1);
      p_addr_q     <= '0;
      p_we_q       <= 1'b0;
      p_wstrb_q    <= '0;
      p_wdata_q    <= '0;
    end else begin
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      p_addr_q     <= p_addr_d;
      p_we_q       <= p_we_d;
      p_wstrb_q    <= p_wstrb_d;
      p_wdata_q    <= p_wdata_d;
    end
  end

  assign p_addr_o  = p_addr_q;
  assign p_we_o    = p_we_q;
  assign p_wstrb_o = p_wstrb_q;
  assign p_wdata_o = p_wdata_q;

  // Output logic.
  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    rsp_err_o   = 1'b0;
    grant_o     = '0;
    p_valid_o   = 1'b0;
    if (live) begin
      case (state_q)
        StIdle: begin
          if (win_found) req_ready_o = win_1h;
        end
        StIssue: begin
          p_valid_o = 1'b1;
          grant_o   = own_1h;
        end
        StWait: begin
          grant_o = own_1h;
          if (rsp_fire) begin
            rsp_valid_o = own_1h;
            if (p_rsp_valid_i) begin
              rsp_data_o = p_rsp_data_i;
              rsp_err_o  = p_rsp_err_i;
            end else begin
              rsp_err_o  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ladybird_bus_arbiter.sv
// Directed bench for ladybird_bus_arbiter: a transaction table plus hand-written reset,
// contention, backpressure and watchdog sequences.
module tb_ladybird_bus_arbiter;

  localparam int unsigned NReq = 2;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned Tmo  = 16;

  logic                         clk_i = 1'b0;
  logic                         anrst_i;
  logic                         nrst;
  logic [NReq-1:0]              req_valid_i;
  logic [NReq-1:0]              req_ready_o;
  logic [NReq-1:0][AW-1:0]      req_addr_i;
  logic [NReq-1:0]              req_we_i;
  logic [NReq-1:0][DW/8-1:0]    req_wstrb_i;
  logic [NReq-1:0][DW-1:0]      req_wdata_i;
  logic [NReq-1:0]              rsp_valid_o;
  logic [DW-1:0]                rsp_data_o;
  logic                         rsp_err_o;
  logic [NReq-1:0]              grant_o;
  logic                         p_valid_o;
  logic                         p_ready_i;
  logic [AW-1:0]                p_addr_o;
  logic                         p_we_o;
  logic [DW/8-1:0]              p_wstrb_o;
  logic [DW-1:0]                p_wdata_o;
  logic                         p_rsp_valid_i;
  logic [DW-1:0]                p_rsp_data_i;
  logic                         p_rsp_err_i;

  int total;
  int bad;
  logic [1:0] exp_g;

  always #5 clk_i = ~clk_i;

  ladybird_bus_arbiter #(
    .N_REQ   (NReq),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (Tmo)
  ) dut (
    .clk_i         (clk_i),
    .anrst_i       (anrst_i),
    .nrst          (nrst),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_addr_i    (req_addr_i),
    .req_we_i      (req_we_i),
    .req_wstrb_i   (req_wstrb_i),
    .req_wdata_i   (req_wdata_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_data_o    (rsp_data_o),
    .rsp_err_o     (rsp_err_o),
    .grant_o       (grant_o),
    .p_valid_o     (p_valid_o),
    .p_ready_i     (p_ready_i),
    .p_addr_o      (p_addr_o),
    .p_we_o        (p_we_o),
    .p_wstrb_o     (p_wstrb_o),
    .p_wdata_o     (p_wdata_o),
    .p_rsp_valid_i (p_rsp_valid_i),
    .p_rsp_data_i  (p_rsp_data_i),
    .p_rsp_err_i   (p_rsp_err_i)
  );

  typedef struct packed {
    logic [1:0]        valid;
    logic [1:0][31:0]  addr;
    logic [1:0]        we;
    logic [1:0][3:0]   strb;
    logic [1:0][31:0]  wdata;
    int unsigned       lat;     // WAIT cycle (1-based) in which the peripheral answers
    logic [31:0]       rdata;
    logic              rerr;
    logic [1:0]        egrant;
    logic [31:0]       eaddr;
    logic              ewe;
    logic [3:0]        estrb;
    logic [31:0]       ewdata;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_ctl"}, {req_ready_o, rsp_valid_o, grant_o, p_valid_o, p_we_o, p_wstrb_o, rsp_err_o},
        '0);
    chk({nm, "_addr"}, p_addr_o, '0);
    chk({nm, "_wdata"}, p_wdata_o, '0);
    chk({nm, "_rdata"}, rsp_data_o, '0);
  endtask

  task automatic run_vec(input int n, input vec_t v);
    req_valid_i = v.valid;
    req_addr_i  = v.addr;
    req_we_i    = v.we;
    req_wstrb_i = v.strb;
    req_wdata_i = v.wdata;
    #1;
    chk($sformatf("v%0d_ready", n), req_ready_o, v.egrant);
    step();
    req_valid_i = '0;
    #1;
    chk($sformatf("v%0d_pvalid", n), p_valid_o, 1'b1);
    chk($sformatf("v%0d_grant", n), grant_o, v.egrant);
    chk($sformatf("v%0d_paddr", n), p_addr_o, v.eaddr);
    chk($sformatf("v%0d_pwe", n), p_we_o, v.ewe);
    chk($sformatf("v%0d_pstrb", n), p_wstrb_o, v.estrb);
    chk($sformatf("v%0d_pwdata", n), p_wdata_o, v.ewdata);
    p_ready_i = 1'b1;
    step();
    p_ready_i = 1'b0;
    for (int i = 1; i < int'(v.lat); i++) begin
      #1;
      chk($sformatf("v%0d_wait%0d", n, i), {rsp_valid_o, grant_o}, {2'b00, v.egrant});
      step();
    end
    p_rsp_valid_i = 1'b1;
    p_rsp_data_i  = v.rdata;
    p_rsp_err_i   = v.rerr;
    #1;
    chk($sformatf("v%0d_rsp_valid", n), rsp_valid_o, v.egrant);
    chk($sformatf("v%0d_rsp_data", n), rsp_data_o, v.rdata);
    chk($sformatf("v%0d_rsp_err", n), rsp_err_o, v.rerr);
    step();
    p_rsp_valid_i = 1'b0;
    p_rsp_data_i  = '0;
    p_rsp_err_i   = 1'b0;
    #1;
    chk($sformatf("v%0d_idle", n), {grant_o, rsp_valid_o, p_valid_o}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    total = 0;
    bad   = 0;
    // Rotation traced by hand from last_owner=1 after reset.
    vecs[0] = '{valid: 2'b01, addr: {32'h9000_0000, 32'h8000_0010}, we: 2'b00,
                strb: {4'h0, 4'hF}, wdata: {32'h0, 32'h0}, lat: 3, rdata: 32'hDEAD_BEEF,
                rerr: 1'b0, egrant: 2'b01, eaddr: 32'h8000_0010, ewe: 1'b0, estrb: 4'hF,
                ewdata: 32'h0};
    vecs[1] = '{valid: 2'b11, addr: {32'h0000_2004, 32'h0000_1000}, we: 2'b10,
                strb: {4'b0011, 4'hF}, wdata: {32'hCAFE_1234, 32'h1111_1111}, lat: 2,
                rdata: 32'h0, rerr: 1'b0, egrant: 2'b10, eaddr: 32'h0000_2004, ewe: 1'b1,
                estrb: 4'b0011, ewdata: 32'hCAFE_1234};
    vecs[2] = '{valid: 2'b11, addr: {32'h0000_3000, 32'h0000_4008}, we: 2'b01,
                strb: {4'h1, 4'hC}, wdata: {32'h2222_2222, 32'hA5A5_5A5A}, lat: 1,
                rdata: 32'h0BAD_0BAD, rerr: 1'b1, egrant: 2'b01, eaddr: 32'h0000_4008,
                ewe: 1'b1, estrb: 4'hC, ewdata: 32'hA5A5_5A5A};
    vecs[3] = '{valid: 2'b01, addr: {32'h0000_5000, 32'h0000_6000}, we: 2'b00,
                strb: {4'hF, 4'hF}, wdata: {32'h0, 32'h0}, lat: 1, rdata: 32'h1234_5678,
                rerr: 1'b0, egrant: 2'b01, eaddr: 32'h0000_6000, ewe: 1'b0, estrb: 4'hF,
                ewdata: 32'h0};
    vecs[4] = '{valid: 2'b10, addr: {32'h7000_0000, 32'h0}, we: 2'b00,
                strb: {4'h8, 4'h0}, wdata: {32'h3333_3333, 32'h0}, lat: 4,
                rdata: 32'h8765_4321, rerr: 1'b0, egrant: 2'b10, eaddr: 32'h7000_0000,
                ewe: 1'b0, estrb: 4'h8, ewdata: 32'h3333_3333};
    vecs[5] = '{valid: 2'b10, addr: {32'hFFFF_FFFC, 32'h1}, we: 2'b10,
                strb: {4'hF, 4'h0}, wdata: {32'hFFFF_FFFF, 32'h0}, lat: 1, rdata: 32'h0,
                rerr: 1'b0, egrant: 2'b10, eaddr: 32'hFFFF_FFFC, ewe: 1'b1, estrb: 4'hF,
                ewdata: 32'hFFFF_FFFF};
    vecs[6] = '{valid: 2'b11, addr: {32'h0000_0044, 32'h0000_0040}, we: 2'b00,
                strb: {4'hF, 4'hF}, wdata: {32'h0, 32'h0}, lat: 2, rdata: 32'h0000_00FF,
                rerr: 1'b0, egrant: 2'b01, eaddr: 32'h0000_0040, ewe: 1'b0, estrb: 4'hF,
                ewdata: 32'h0};

    anrst_i       = 1'b0;
    nrst          = 1'b1;
    req_valid_i   = '0;
    req_addr_i    = '0;
    req_we_i      = '0;
    req_wstrb_i   = '0;
    req_wdata_i   = '0;
    p_ready_i     = 1'b0;
    p_rsp_valid_i = 1'b0;
    p_rsp_data_i  = '0;
    p_rsp_err_i   = 1'b0;
    #2;
    chk_quiet("por");
    repeat (2) @(posedge clk_i);
    #1;
    anrst_i = 1'b1;
    #1;
    chk_quiet("por_release");
    step();

    for (int n = 0; n < 7; n++) begin
      run_vec(n, vecs[n]);
    end

    // Async reset in ISSUE, then synchronous reset held two cycles with a request pending.
    req_valid_i = 2'b01;
    req_addr_i  = {32'h0000_0BBB, 32'h1234_5678};
    req_wdata_i = {32'h0, 32'h9999_9999};
    req_wstrb_i = {4'h0, 4'hF};
    req_we_i    = 2'b01;
    #1;
    chk("mid_ready", req_ready_o, 2'b01);
    step();
    #1;
    chk("mid_issue", p_valid_o, 1'b1);
    anrst_i = 1'b0;
    #1;
    chk_quiet("async_rst");
    anrst_i = 1'b1;
    nrst    = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      #1;
      chk_quiet($sformatf("sync_rst%0d", c));
    end
    nrst = 1'b1;

    // Contention: both valid for six transactions, grants must alternate from requester 0.
    req_valid_i = 2'b11;
    req_addr_i  = {32'hB000_0000, 32'hA000_0000};
    req_we_i    = 2'b00;
    for (int k = 0; k < 6; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      chk($sformatf("cont%0d_ready", k), req_ready_o, exp_g);
      step();
      #1;
      chk($sformatf("cont%0d_grant", k), grant_o, exp_g);
      chk($sformatf("cont%0d_busy_ready", k), req_ready_o, 2'b00);
      chk($sformatf("cont%0d_paddr", k), p_addr_o,
          (exp_g == 2'b01) ? 32'hA000_0000 : 32'hB000_0000);
      p_ready_i = 1'b1;
      step();
      p_ready_i     = 1'b0;
      p_rsp_valid_i = 1'b1;
      p_rsp_data_i  = 32'(k + 32'h100);
      #1;
      chk($sformatf("cont%0d_rsp", k), rsp_valid_o, exp_g);
      chk($sformatf("cont%0d_rdata", k), rsp_data_o, 32'(k + 32'h100));
      step();
      p_rsp_valid_i = 1'b0;
    end
    req_valid_i = '0;
    #1;

    // Backpressure: five stalled ISSUE cycles while requester 1 keeps changing its inputs.
    req_valid_i    = 2'b10;
    req_addr_i[1]  = 32'h0000_0C00;
    req_wdata_i[1] = 32'h5555_AAAA;
    req_wstrb_i[1] = 4'b1010;
    req_we_i       = 2'b10;
    #1;
    chk("bp_ready", req_ready_o, 2'b10);
    step();
    for (int i = 0; i < 5; i++) begin
      req_addr_i[1]  = 32'(32'h100 * (i + 1));
      req_wdata_i[1] = 32'(i) ^ 32'hFFFF_0000;
      req_wstrb_i[1] = 4'(i);
      p_rsp_valid_i  = (i == 2);
      #1;
      chk($sformatf("bp%0d_pvalid", i), p_valid_o, 1'b1);
      chk($sformatf("bp%0d_hold", i), {p_addr_o, p_wstrb_o, p_we_o},
          {32'h0000_0C00, 4'b1010, 1'b1});
      chk($sformatf("bp%0d_wdata", i), p_wdata_o, 32'h5555_AAAA);
      chk($sformatf("bp%0d_quiet", i), {req_ready_o, rsp_valid_o}, 4'b0000);
      step();
    end
    p_rsp_valid_i = 1'b0;
    p_ready_i     = 1'b1;
    #1;
    chk("bp6_pvalid", p_valid_o, 1'b1);
    chk("bp6_hold", p_addr_o, 32'h0000_0C00);
    step();
    p_ready_i = 1'b0;
    #1;
    chk("bp_wait", {grant_o, p_valid_o}, {2'b10, 1'b0});
    req_valid_i   = '0;
    p_rsp_valid_i = 1'b1;
    p_rsp_data_i  = 32'h0;
    #1;
    chk("bp_ack", rsp_valid_o, 2'b10);
    step();
    p_rsp_valid_i = 1'b0;

`ifdef LADYBIRD_ARB_TIMEOUT_EN
    // Silent peripheral: watchdog answers on the 16th WAIT cycle.
    p_rsp_data_i = 32'hFFFF_FFFF;
    req_valid_i  = 2'b01;
    #1;
    chk("tmo_ready", req_ready_o, 2'b01);
    step();
    req_valid_i = '0;
    p_ready_i   = 1'b1;
    step();
    p_ready_i = 1'b0;
    for (int w = 1; w < 16; w++) begin
      #1;
      chk($sformatf("tmo_quiet%0d", w), rsp_valid_o, 2'b00);
      step();
    end
    #1;
    chk("tmo_rsp", rsp_valid_o, 2'b01);
    chk("tmo_err", rsp_err_o, 1'b1);
    chk("tmo_data", rsp_data_o, 32'h0);
    step();
    req_valid_i = 2'b10;
    #1;
    chk("tmo_next_ready", req_ready_o, 2'b10);
    step();
    req_valid_i = '0;
    p_ready_i   = 1'b1;
    step();
    p_ready_i     = 1'b0;
    p_rsp_valid_i = 1'b1;
    p_rsp_data_i  = 32'h0000_0042;
    #1;
    chk("tmo_next_rsp", {rsp_valid_o, rsp_err_o}, {2'b10, 1'b0});
    step();
    p_rsp_valid_i = 1'b0;
`else
    // No watchdog: WAIT must hold through a long silence.
    req_valid_i = 2'b01;
    #1;
    chk("hold_ready", req_ready_o, 2'b01);
    step();
    req_valid_i = '0;
    p_ready_i   = 1'b1;
    step();
    p_ready_i = 1'b0;
    repeat (40) step();
    #1;
    chk("hold_wait", {grant_o, rsp_valid_o, rsp_err_o}, {2'b01, 2'b00, 1'b0});
    p_rsp_valid_i = 1'b1;
    p_rsp_data_i  = 32'h0000_0042;
    #1;
    chk("hold_rsp", rsp_valid_o, 2'b01);
    chk("hold_rdata", rsp_data_o, 32'h0000_0042);
    step();
    p_rsp_valid_i = 1'b0;
    #1;
    chk("hold_idle", grant_o, 2'b00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
